hazard_tracker: RTL and testbench



---
 rtl/core_pkg.sv | 16 +
 rtl/operand_resolver.sv | 40 ++++
 rtl/hazard_tracker.sv | 106 ++++++++++
 tb/tb_hazard_tracker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants and in-flight write metadata for the RV32E hazard tracker.
package core_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 4;
   localparam int unsigned LAT_W  = 2;

   // One post-ID pipeline slot: who writes what, and from which slot the result is on the bus
   typedef struct packed {
      logic              valid;
      logic              we;
      logic [REG_AW-1:0] rd;
      logic [LAT_W-1:0]  lat;
   } inflight_entry_t;

endpackage

// File: rtl/operand_resolver.sv
// Resolves one ID-stage source operand against the in-flight write entries.
module operand_resolver
   import core_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = XLEN
) (
   input  inflight_entry_t       i_entries [DEPTH],
   input  logic [REG_AW-1:0]     i_rs,
   input  logic                  i_rs_en,
   input  logic [DW-1:0]         i_rf_data,
   input  logic [DEPTH*DW-1:0]   i_stage_data,
   output logic [DW-1:0]         o_data,
   output logic                  o_fwd,
   output logic                  o_unresolved
);

   // Priority search: scan oldest to youngest so the lowest matching index wins
   always_comb begin
      o_data       = i_rf_data;
      o_fwd        = 1'b0;
      o_unresolved = 1'b0;
      if (i_rs_en && (i_rs != '0)) begin
         for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (i_entries[i].valid && i_entries[i].we && (i_entries[i].rd == i_rs)) begin
               if (int'(i_entries[i].lat) <= i) begin
                  o_data       = i_stage_data[i*int'(DW) +: DW];
                  o_fwd        = 1'b1;
                  o_unresolved = 1'b0;
               end else begin
                  o_data       = i_rf_data;
                  o_fwd        = 1'b0;
                  o_unresolved = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/hazard_tracker.sv
// In-flight write tracker: destination shift register, operand forwarding/stall and perf counters.
// XLEN/REG_AW/LAT_W must match core_pkg since the entry struct is declared there.
module hazard_tracker
   import core_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned XLEN   = core_pkg::XLEN,
   parameter int unsigned REG_AW = core_pkg::REG_AW,
   parameter int unsigned LAT_W  = core_pkg::LAT_W,
   parameter int unsigned CNT_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    id_valid,
   input  logic [REG_AW-1:0]       id_rs1,
   input  logic [REG_AW-1:0]       id_rs2,
   input  logic                    id_rs1_en,
   input  logic                    id_rs2_en,
   input  logic [REG_AW-1:0]       id_rd,
   input  logic                    id_we,
   input  logic [LAT_W-1:0]        id_lat,
   input  logic                    flush,
   input  logic [XLEN-1:0]         rf_rs1_data,
   input  logic [XLEN-1:0]         rf_rs2_data,
   input  logic [DEPTH*XLEN-1:0]   stage_data,
   output logic [XLEN-1:0]         rs1_data,
   output logic [XLEN-1:0]         rs2_data,
   output logic                    fwd_rs1,
   output logic                    fwd_rs2,
   output logic                    stall,
   output logic                    wb_we,
   output logic [REG_AW-1:0]       wb_rd,
   output logic [CNT_W-1:0]        perf_stall_cnt,
   output logic [CNT_W-1:0]        perf_fwd_cnt
);

   inflight_entry_t    r_entries [DEPTH];
   inflight_entry_t    w_new_entry;
   logic               w_rs1_unres;
   logic               w_rs2_unres;
   logic               w_issue;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic [CNT_W-1:0]   r_fwd_cnt;

   operand_resolver #(.DEPTH(DEPTH), .DW(XLEN)) u_res_rs1 (
      .i_entries    (r_entries),
      .i_rs         (id_rs1),
      .i_rs_en      (id_rs1_en),
      .i_rf_data    (rf_rs1_data),
      .i_stage_data (stage_data),
      .o_data       (rs1_data),
      .o_fwd        (fwd_rs1),
      .o_unresolved (w_rs1_unres)
   );

   operand_resolver #(.DEPTH(DEPTH), .DW(XLEN)) u_res_rs2 (
      .i_entries    (r_entries),
      .i_rs         (id_rs2),
      .i_rs_en      (id_rs2_en),
      .i_rf_data    (rf_rs2_data),
      .i_stage_data (stage_data),
      .o_data       (rs2_data),
      .o_fwd        (fwd_rs2),
      .o_unresolved (w_rs2_unres)
   );

   // Stall on any unresolved source; a flushed ID instruction never stalls
   assign stall   = id_valid & ~flush & (w_rs1_unres | w_rs2_unres);
   assign w_issue = id_valid & ~stall & ~flush;

   // Writes to x0 are dropped at entry so they never match a source
   always_comb begin
      w_new_entry       = '0;
      w_new_entry.valid = 1'b1;
      w_new_entry.we    = id_we & (id_rd != '0);
      w_new_entry.rd    = id_rd;
      w_new_entry.lat   = id_lat;
   end

   // Free-running shift register: the ID instruction or a bubble enters entry 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) r_entries[i] <= '0;
      end else begin
         r_entries[0] <= w_issue ? w_new_entry : '0;
         for (int i = 1; i < int'(DEPTH); i++) r_entries[i] <= r_entries[i-1];
      end
   end

   // Saturating stall and forward-use counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else begin
         if (stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_issue && (fwd_rs1 || fwd_rs2) && (r_fwd_cnt != '1)) r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
      end
   end

   assign wb_we          = r_entries[DEPTH-1].valid & r_entries[DEPTH-1].we;
   assign wb_rd          = r_entries[DEPTH-1].rd;
   assign perf_stall_cnt = r_stall_cnt;
   assign perf_fwd_cnt   = r_fwd_cnt;

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed scenarios plus random traffic against a slot model.
module tb_hazard_tracker;

   localparam int DEPTH   = 4;
   localparam int XLEN    = 32;
   localparam int REG_AW  = 4;
   localparam int LAT_W   = 2;
   localparam int CNT_W   = 3;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  id_valid;
   logic [REG_AW-1:0]     id_rs1, id_rs2, id_rd;
   logic                  id_rs1_en, id_rs2_en, id_we;
   logic [LAT_W-1:0]      id_lat;
   logic                  flush;
   logic [XLEN-1:0]       rf_rs1_data, rf_rs2_data;
   logic [DEPTH*XLEN-1:0] stage_data;
   logic [XLEN-1:0]       rs1_data, rs2_data;
   logic                  fwd_rs1, fwd_rs2, stall, wb_we;
   logic [REG_AW-1:0]     wb_rd;
   logic [CNT_W-1:0]      perf_stall_cnt, perf_fwd_cnt;

   always #5 clk = ~clk;

   hazard_tracker #(
      .DEPTH(DEPTH), .XLEN(XLEN), .REG_AW(REG_AW), .LAT_W(LAT_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
      .id_rd(id_rd), .id_we(id_we), .id_lat(id_lat), .flush(flush),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .stage_data(stage_data),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
      .stall(stall), .wb_we(wb_we), .wb_rd(wb_rd),
      .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
   );

   // A writer whose result slot lies beyond the tracked stages can never be forwarded
   always @(posedge clk) begin
      if (rst_n && id_valid && !flush && !stall)
         assert (int'(id_lat) < DEPTH) else $error("FAIL lat_range id_lat=%0d", id_lat);
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: per-slot writer records indexed by age (0 = youngest, in EX)
   bit          m_valid [DEPTH];
   bit          m_we    [DEPTH];
   int          m_rd    [DEPTH];
   int          m_lat   [DEPTH];
   logic [31:0] sd      [DEPTH];
   int          m_scnt, m_fcnt;
   bit          e_stall, e_f1, e_f2;

   function automatic void resolve(input int rs, input bit en, input logic [31:0] rf,
                                   output logic [31:0] data, output bit fwd, output bit unres);
      data = rf; fwd = 0; unres = 0;
      if (en && rs != 0) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && m_we[i] && m_rd[i] == rs) begin
               if (m_lat[i] <= i) begin data = sd[i]; fwd = 1; end
               else unres = 1;
               break;
            end
         end
      end
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 0; m_we[i] = 0; m_rd[i] = 0; m_lat[i] = 0;
      end
      m_scnt = 0; m_fcnt = 0;
   endtask

   task automatic drive_sd();
      for (int i = 0; i < DEPTH; i++) stage_data[i*XLEN +: XLEN] = sd[i];
   endtask

   task automatic check_now();
      logic [31:0] d1, d2;
      bit u1, u2, f1, f2;
      resolve(int'(id_rs1), id_rs1_en, rf_rs1_data, d1, f1, u1);
      resolve(int'(id_rs2), id_rs2_en, rf_rs2_data, d2, f2, u2);
      e_f1 = f1; e_f2 = f2;
      e_stall = id_valid && !flush && (u1 || u2);
      chk("rs1_data", rs1_data, d1);
      chk("rs2_data", rs2_data, d2);
      chk("fwd_rs1", 32'(fwd_rs1), 32'(f1));
      chk("fwd_rs2", 32'(fwd_rs2), 32'(f2));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("wb_we", 32'(wb_we), 32'(m_valid[DEPTH-1] && m_we[DEPTH-1]));
      chk("wb_rd", 32'(wb_rd), 32'(m_rd[DEPTH-1]));
      chk("perf_stall_cnt", 32'(perf_stall_cnt), 32'(m_scnt));
      chk("perf_fwd_cnt", 32'(perf_fwd_cnt), 32'(m_fcnt));
   endtask

   task automatic sample();
      @(negedge clk);
      check_now();
   endtask

   // Advance the model on the same edge as the DUT, using this cycle's inputs
   task automatic tick();
      bit issue;
      @(posedge clk);
      issue = id_valid && !flush && !e_stall;
      if (e_stall && m_scnt < CNT_MAX) m_scnt++;
      if (issue && (e_f1 || e_f2) && m_fcnt < CNT_MAX) m_fcnt++;
      for (int i = DEPTH - 1; i > 0; i--) begin
         m_valid[i] = m_valid[i-1]; m_we[i] = m_we[i-1];
         m_rd[i] = m_rd[i-1]; m_lat[i] = m_lat[i-1];
      end
      m_valid[0] = issue;
      m_we[0]    = issue && id_we && (id_rd != '0);
      m_rd[0]    = issue ? int'(id_rd) : 0;
      m_lat[0]   = issue ? int'(id_lat) : 0;
      #1;
   endtask

   task automatic issue_id(input bit v, input int rs1, input bit e1, input int rs2, input bit e2,
                           input int rd, input bit we, input int lat, input bit fl);
      id_valid = v; id_rs1 = 4'(rs1); id_rs1_en = e1; id_rs2 = 4'(rs2); id_rs2_en = e2;
      id_rd = 4'(rd); id_we = we; id_lat = 2'(lat); flush = fl;
   endtask

   task automatic rand_data();
      rf_rs1_data = $urandom; rf_rs2_data = $urandom;
      for (int i = 0; i < DEPTH; i++) sd[i] = $urandom;
      drive_sd();
   endtask

   // Asynchronous reset asserted away from any clock edge; checked before the next edge
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      model_clear();
      check_now();
      chk("rst_wb_we", 32'(wb_we), 32'd0);
      chk("rst_stall_cnt", 32'(perf_stall_cnt), 32'd0);
      chk("rst_fwd_cnt", 32'(perf_fwd_cnt), 32'd0);
      @(negedge clk);
      id_valid = 1'b0; flush = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      issue_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rand_data();
      #1;
      do_reset();

      // ALU back-to-back forwarding
      issue_id(1, 0, 0, 0, 0, 5, 1, 0, 0); sample(); tick();
      issue_id(1, 5, 1, 0, 0, 0, 0, 0, 0); sd[0] = 32'h0000_1234; drive_sd();
      sample();
      chk("t1_rs1_data", rs1_data, 32'h0000_1234);
      chk("t1_fwd_rs1", 32'(fwd_rs1), 32'd1);
      chk("t1_stall", 32'(stall), 32'd0);
      tick();
      issue_id(0, 0, 0, 0, 0, 0, 0, 0, 0); sample();
      chk("t1_fwd_cnt", 32'(perf_fwd_cnt), 32'd1);
      tick();

      // Load-use: two stall cycles then forward from entry 2
      do_reset();
      rand_data();
      issue_id(1, 0, 0, 0, 0, 3, 1, 2, 0); sample(); tick();
      issue_id(1, 3, 1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         rand_data();
         sample();
         if (k < 2) chk("t2_stall", 32'(stall), 32'd1);
         else begin
            chk("t2_stall_end", 32'(stall), 32'd0);
            chk("t2_rs1_data", rs1_data, sd[2]);
            chk("t2_fwd_rs1", 32'(fwd_rs1), 32'd1);
         end
         tick();
      end
      issue_id(0, 0, 0, 0, 0, 0, 0, 0, 0); sample();
      chk("t2_stall_cnt", 32'(perf_stall_cnt), 32'd2);
      tick();

      // Youngest writer wins
      issue_id(1, 0, 0, 0, 0, 4, 1, 0, 0); sample(); tick();
      issue_id(1, 0, 0, 0, 0, 1, 1, 0, 0); sample(); tick();
      issue_id(1, 0, 0, 0, 0, 4, 1, 0, 0); sample(); tick();
      issue_id(1, 0, 0, 4, 1, 0, 0, 0, 0);
      sd[0] = 32'h0000_AAAA; sd[2] = 32'h0000_BBBB; drive_sd();
      sample();
      chk("t3_rs2_data", rs2_data, 32'h0000_AAAA);
      chk("t3_fwd_rs2", 32'(fwd_rs2), 32'd1);
      tick();

      // x0 writes never create hazards; disabled source ignores an in-flight load
      issue_id(1, 0, 0, 0, 0, 0, 1, 0, 0); sample(); tick();
      issue_id(1, 0, 1, 0, 0, 0, 0, 0, 0); rf_rs1_data = 32'd0; sample();
      chk("t4_fwd_rs1", 32'(fwd_rs1), 32'd0);
      chk("t4_stall", 32'(stall), 32'd0);
      chk("t4_rs1_data", rs1_data, 32'd0);
      tick();
      issue_id(1, 0, 0, 0, 0, 6, 1, 2, 0); sample(); tick();
      issue_id(1, 0, 0, 6, 0, 0, 0, 0, 0); sample();
      chk("t4_rs2_disabled_stall", 32'(stall), 32'd0);
      tick();

      // Flush discards the ID instruction
      do_reset();
      rand_data();
      issue_id(1, 0, 0, 0, 0, 7, 1, 2, 1); sample();
      chk("t5_stall", 32'(stall), 32'd0);
      tick();
      issue_id(1, 7, 1, 0, 0, 0, 0, 0, 0); sample();
      chk("t5_fwd_rs1", 32'(fwd_rs1), 32'd0);
      chk("t5_stall_next", 32'(stall), 32'd0);
      chk("t5_rs1_data", rs1_data, rf_rs1_data);
      tick();

      // Mid-stream reset with all four entries valid
      issue_id(1, 0, 0, 0, 0, 1, 1, 0, 0); sample(); tick();
      issue_id(1, 1, 1, 0, 0, 2, 1, 0, 0); sample(); tick();
      issue_id(1, 0, 0, 0, 0, 3, 1, 0, 0); sample(); tick();
      issue_id(1, 0, 0, 0, 0, 4, 1, 0, 0); sample(); tick();
      issue_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t6_pre_wb_we", 32'(wb_we), 32'd1);
      do_reset();

      // Stall counter saturation: nine stall cycles on a 3-bit counter
      for (int r = 0; r < 3; r++) begin
         issue_id(1, 0, 0, 0, 0, 2, 1, 3, 0); sample(); tick();
         issue_id(1, 2, 1, 0, 0, 0, 0, 0, 0);
         for (int k = 0; k < 4; k++) begin sample(); tick(); end
      end
      issue_id(0, 0, 0, 0, 0, 0, 0, 0, 0); sample();
      chk("t6_stall_sat", 32'(perf_stall_cnt), 32'd7);
      tick();

      // Random traffic against the model
      for (int n = 0; n < 1500; n++) begin
         id_valid  = ($urandom_range(0, 9) < 8);
         id_rs1    = 4'($urandom_range(0, 7));
         id_rs2    = 4'($urandom_range(0, 7));
         id_rs1_en = 1'($urandom_range(0, 1));
         id_rs2_en = 1'($urandom_range(0, 1));
         id_rd     = 4'($urandom_range(0, 7));
         id_we     = ($urandom_range(0, 3) != 0);
         id_lat    = 2'($urandom_range(0, 3));
         flush     = ($urandom_range(0, 9) == 0);
         rand_data();
         sample();
         tick();
         if (n == 700) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
